desorb_sequencer: RTL
=====================

Name: desorb_sequencer

Overview:
- Controller that sequences the PWM desorption heater.
- Walks a one-shot thermal profile PREHEAT -> DESORB -> COOL with programmable phase durations.
- Drives the PWM core's 2-bit state and reference-level selects from registered outputs.
- Sits between the pad inputs and the PWM core in the user project; the PWM core is unchanged.

Parameters:
- PRESCALE, 1000, clk_i cycles per duration unit (>=1)
- PRESCALE_W, 16, prescaler counter width (must hold PRESCALE-1)
- LEN_W, 8, width of phase-length inputs and the phase unit counter

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  start-profile request, level-sampled each cycle
- abort_i  input  1  abort request, level-sampled each cycle
- preheat_len_i  input  LEN_W  PREHEAT duration in units
- desorb_len_i  input  LEN_W  DESORB duration in units
- cool_len_i  input  LEN_W  COOL duration in units
- preheat_ref_i  input  2  reference level applied during PREHEAT
- state_bits_o  output  2  phase code to PWM core: IDLE=00, PREHEAT=01, DESORB=10, COOL=11
- ref_bits_o  output  2  reference level to PWM core
- busy_o  output  1  high while not IDLE
- done_o  output  1  one-cycle pulse on normal profile completion

Behaviour:
- Reset (rst_i high at a clk_i edge): state IDLE, prescaler=0, unit counter=0, all outputs 0, latched config cleared. Reset mid-profile takes effect on that edge.
- All outputs are registered. state_bits_o equals the FSM state code.
- ref_bits_o by phase: IDLE=00, PREHEAT=latched preheat_ref, DESORB=11, COOL=00.
- busy_o = (state != IDLE).
- Start: accepted only in IDLE with abort_i low.
  - On acceptance, latch all three lengths and preheat_ref_i.
  - On the next edge, enter the first phase whose latched length is non-zero.
  - start_i while busy is ignored; inputs are not re-sampled mid-profile.
- Zero-length phases are skipped: the FSM goes directly to the next non-zero phase, or completes.
- All lengths zero: start is accepted, state stays IDLE, done_o pulses on the cycle after start, busy_o never asserts.
- Timing:
  - On phase entry, prescaler and unit counter clear to 0.
  - The prescaler counts 0..PRESCALE-1 and produces a unit tick when it equals PRESCALE-1.
  - Each tick increments the unit counter. On the tick where the unit counter equals len-1, the FSM transitions.
  - A phase therefore occupies exactly len*PRESCALE cycles of state_bits_o.
- Completion: when COOL finishes (or the last non-zero phase finishes), go to IDLE. done_o is high for exactly the first IDLE cycle.
- Abort: abort_i high in any non-IDLE state -> IDLE on the next edge. Counters cleared, ref_bits_o=00, no done_o pulse.
  - abort_i in IDLE has no effect, but it blocks a simultaneous start_i (abort wins).
- Maximum length (2^LEN_W-1) must work with no counter overflow or wrap. The unit counter never exceeds len-1.
- start_i held high continuously after completion re-triggers on the first IDLE cycle; done_o and the re-start coincide.

Optional Feature:
- Macro DESORB_SEQ_REPEAT_EN.
- Defined:
  - Adds port repeat_i (input, 4 bits), latched at start.
  - After COOL completes, if the remaining-repeat count is >0, decrement it and re-enter the first non-zero phase (PREHEAT if non-zero) with no IDLE cycle in between.
  - done_o pulses only after the final pass. repeat_i=0 means one pass; repeat_i=3 means four passes.
  - Abort clears the remaining count.
- Undefined: no repeat_i port, single pass, behaviour exactly as above.

Decomposition:
- Package desorb_pkg holds:
  - phase enum with codes IDLE/PREHEAT/DESORB/COOL = 00/01/10/11
  - constant REF_FULL = 2'b11
  - constant REF_OFF = 2'b00
- One sub-module, desorb_tick_gen: the PRESCALE prescaler with a synchronous clear input and a one-cycle tick output.
- The FSM, unit counter and output registers stay in desorb_sequencer.

Test Plan:
All scenarios run with PRESCALE=4.
- Reset: rst_i high 3 cycles with start_i high -> all outputs 0, busy_o 0, no done_o.
- Nominal profile: lengths 2/3/1, preheat_ref=01, start pulse -> state 01 for 8 cycles with ref 01, then state 10 for 12 cycles with ref 11, then state 11 for 4 cycles with ref 00, then IDLE with done_o high for exactly 1 cycle.
- Skip phase: lengths 0/2/0 -> only state 10 for 8 cycles, then done_o. Separately, lengths 0/0/0 -> done_o on the cycle after start, busy_o stays 0.
- Abort: same as nominal, abort_i raised in cycle 5 of DESORB -> IDLE next edge, ref_bits_o 00, no done_o. Then start+abort asserted together in IDLE -> stays IDLE.
- Start during busy and input change: change the length inputs and pulse start_i mid-PREHEAT -> profile timing unchanged.
- Max length and repeat: LEN=255 on DESORB -> exactly 1020 cycles. With DESORB_SEQ_REPEAT_EN and repeat_i=2, lengths 1/1/1 -> three back-to-back passes of 12 cycles, one done_o.

Source files
------------

// File: rtl/desorb_pkg.sv
// Shared types and helpers for the desorption heater sequencer.
// Phase codes match the 2-bit state select expected by the PWM core.
package desorb_pkg;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'b00,
    PH_PREHEAT = 2'b01,
    PH_DESORB  = 2'b10,
    PH_COOL    = 2'b11
  } phase_e;

  localparam logic [1:0] REF_FULL = 2'b11;
  localparam logic [1:0] REF_OFF  = 2'b00;

  // nz[0]=preheat, nz[1]=desorb, nz[2]=cool non-zero; returns first non-zero phase after cur
  function automatic phase_e next_phase(input phase_e cur, input logic [2:0] nz);
    phase_e nxt;
    nxt = PH_IDLE;
    case (cur)
      PH_IDLE: begin
        if (nz[0])      nxt = PH_PREHEAT;
        else if (nz[1]) nxt = PH_DESORB;
        else if (nz[2]) nxt = PH_COOL;
      end
      PH_PREHEAT: begin
        if (nz[1])      nxt = PH_DESORB;
        else if (nz[2]) nxt = PH_COOL;
      end
      PH_DESORB: begin
        if (nz[2])      nxt = PH_COOL;
      end
      default: nxt = PH_IDLE;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] phase_ref(input phase_e ph, input logic [1:0] pre_ref);
    logic [1:0] r;
    case (ph)
      PH_PREHEAT: r = pre_ref;
      PH_DESORB:  r = REF_FULL;
      default:    r = REF_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/desorb_tick_gen.sv
// Duration-unit prescaler: counts 0..PRESCALE-1 and flags the last count.
// clear_i forces the count back to zero on the next edge.
module desorb_tick_gen #(
  parameter int PRESCALE   = 1000,
  parameter int PRESCALE_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == LAST);
    if (clear_i || tick_o) cnt_d = '0;
    else                   cnt_d = cnt_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/desorb_sequencer.sv
// One-shot PREHEAT -> DESORB -> COOL profile sequencer driving the PWM heater core.
// Optional multi-pass support is enabled with `define DESORB_SEQ_REPEAT_EN.
//
// state      | meaning
// PH_IDLE    | waiting for start, heater off
// PH_PREHEAT | preheat phase, latched preheat reference
// PH_DESORB  | desorb phase, full reference
// PH_COOL    | cool-down phase, reference off
module desorb_sequencer
  import desorb_pkg::*;
#(
  parameter int PRESCALE   = 1000,
  parameter int PRESCALE_W = 16,
  parameter int LEN_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] preheat_len_i,
  input  logic [LEN_W-1:0] desorb_len_i,
  input  logic [LEN_W-1:0] cool_len_i,
  input  logic [1:0]       preheat_ref_i,
`ifdef DESORB_SEQ_REPEAT_EN
  input  logic [3:0]       repeat_i,
`endif
  output logic [1:0]       state_bits_o,
  output logic [1:0]       ref_bits_o,
  output logic             busy_o,
  output logic             done_o
);

  phase_e           state_q;
  logic [LEN_W-1:0] pre_len_q, des_len_q, cool_len_q;
  logic [LEN_W-1:0] unit_q;
  logic [1:0]       pre_ref_q;
  logic [1:0]       ref_q;
  logic             busy_q, done_q;
`ifdef DESORB_SEQ_REPEAT_EN
  logic [3:0]       rep_q;
`endif

  logic             tick, tick_clear;
  logic             start_ok, unit_last, rep_more;
  logic [LEN_W-1:0] cur_len;
  logic [2:0]       nz_in, nz_q;
  phase_e           first_d, after_d, restart_d;

  // Prescaler is held at zero in IDLE and on abort so every phase entry starts aligned.
  assign tick_clear = (state_q == PH_IDLE) || abort_i;

  desorb_tick_gen #(
    .PRESCALE  (PRESCALE),
    .PRESCALE_W(PRESCALE_W)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(tick_clear),
    .tick_o (tick)
  );

  always_comb begin
    case (state_q)
      PH_PREHEAT: cur_len = pre_len_q;
      PH_DESORB:  cur_len = des_len_q;
      PH_COOL:    cur_len = cool_len_q;
      default:    cur_len = '0;
    endcase
    unit_last = (unit_q == cur_len - LEN_W'(1));
    start_ok  = (state_q == PH_IDLE) && start_i && !abort_i;
    nz_in     = {|cool_len_i, |desorb_len_i, |preheat_len_i};
    nz_q      = {|cool_len_q, |des_len_q, |pre_len_q};
    first_d   = next_phase(PH_IDLE, nz_in);
    after_d   = next_phase(state_q, nz_q);
    restart_d = next_phase(PH_IDLE, nz_q);
`ifdef DESORB_SEQ_REPEAT_EN
    rep_more  = (rep_q != 4'd0);
`else
    rep_more  = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= PH_IDLE;
      pre_len_q  <= '0;
      des_len_q  <= '0;
      cool_len_q <= '0;
      pre_ref_q  <= 2'b00;
      unit_q     <= '0;
      ref_q      <= REF_OFF;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DESORB_SEQ_REPEAT_EN
      rep_q      <= 4'd0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q == PH_IDLE) begin
        unit_q <= '0;
        if (start_ok) begin
          pre_len_q  <= preheat_len_i;
          des_len_q  <= desorb_len_i;
          cool_len_q <= cool_len_i;
          pre_ref_q  <= preheat_ref_i;
`ifdef DESORB_SEQ_REPEAT_EN
          rep_q      <= repeat_i;
`endif
          state_q    <= first_d;
          ref_q      <= phase_ref(first_d, preheat_ref_i);
          busy_q     <= (first_d != PH_IDLE);
          done_q     <= (first_d == PH_IDLE);
        end
      end else if (abort_i) begin
        state_q <= PH_IDLE;
        unit_q  <= '0;
        ref_q   <= REF_OFF;
        busy_q  <= 1'b0;
`ifdef DESORB_SEQ_REPEAT_EN
        rep_q   <= 4'd0;
`endif
      end else if (tick) begin
        if (unit_last) begin
          unit_q <= '0;
          if (after_d == PH_IDLE && rep_more) begin
            // Another pass: go straight back to the first non-zero phase.
`ifdef DESORB_SEQ_REPEAT_EN
            rep_q <= rep_q - 4'd1;
`endif
            state_q <= restart_d;
            ref_q   <= phase_ref(restart_d, pre_ref_q);
          end else begin
            state_q <= after_d;
            ref_q   <= phase_ref(after_d, pre_ref_q);
            busy_q  <= (after_d != PH_IDLE);
            done_q  <= (after_d == PH_IDLE);
          end
        end else begin
          unit_q <= unit_q + LEN_W'(1);
        end
      end
    end
  end

  assign state_bits_o = state_q;
  assign ref_bits_o   = ref_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
